// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padding into 512-bit blocks with first/final flags
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [511:0] block,
  output logic         block_first,
  output logic         block_final
);
  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;
  state_t state;
  logic [3:0] widx;
  logic [LEN_W-1:0] bitcnt;
  logic pend80, done, lph;
  logic [2:0] n;
  logic [31:0] last_word;
  logic [63:0] len;
  assign n = in_nbytes > 3'd4 ? 3'd4 : in_nbytes;
  assign len = 64'(bitcnt);
  assign in_ready = (state == FILL) & reset_n;
  // last word keeps its n valid bytes, places the 0x80 marker right after them, zeroes the rest
  always_comb begin
    last_word = '0;
    for (int b = 0; b < 4; b++)
      last_word[31-8*b -: 8] = (3'(b) < n) ? in_data[31-8*b -: 8] : (3'(b) == n ? 8'h80 : 8'h00);
  end
  // fill, pad, length and emit sequencing; word widx lives at block[(15-widx)*32 +: 32]
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= FILL;
      widx        <= '0;
      bitcnt      <= '0;
      pend80      <= 1'b0;
      done        <= 1'b0;
      lph         <= 1'b0;
      block       <= '0;
      block_valid <= 1'b0;
      block_first <= 1'b1;
      block_final <= 1'b0;
    end else begin
      case (state)
        FILL: if (in_valid) begin
          block[{~widx, 5'b0} +: 32] <= in_last ? last_word : in_data;
          bitcnt <= bitcnt + (in_last ? LEN_W'({n, 3'b0}) : LEN_W'(32));
          if (in_last) begin
            done   <= 1'b1;
            pend80 <= (n == 3'd4);
          end
          if (widx == 4'd15) begin
            state       <= EMIT;
            block_valid <= 1'b1;
          end else begin
            widx  <= widx + 4'd1;
            state <= in_last ? PAD : FILL;
          end
        end
        PAD: if (widx == 4'd14 && !pend80) state <= LEN;
        else begin
          block[{~widx, 5'b0} +: 32] <= pend80 ? 32'h8000_0000 : 32'h0;
          pend80 <= 1'b0;
          if (widx == 4'd15) begin
            state       <= EMIT;
            block_valid <= 1'b1;
          end else widx <= widx + 4'd1;
        end
        LEN: if (!lph) begin
          block[63:32] <= len[63:32];
          lph          <= 1'b1;
        end else begin
          block[31:0] <= len[31:0];
          lph         <= 1'b0;
          block_final <= 1'b1;
          block_valid <= 1'b1;
          state       <= EMIT;
        end
        default: if (block_ready) begin
          block_valid <= 1'b0;
          widx        <= '0;
          block       <= '0;
          if (block_final) begin
            state       <= FILL;
            bitcnt      <= '0;
            block_first <= 1'b1;
            done        <= 1'b0;
            block_final <= 1'b0;
          end else begin
            block_first <= 1'b0;
            state       <= done ? PAD : FILL;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: random and directed messages checked against a byte-level FIPS 180-4 padding model
module tb_sha256_padder;
  typedef logic [7:0] bytes_t[$];
  typedef logic [511:0] blocks_t[$];
  logic clk = 0, reset_n = 0, in_valid = 0, in_last = 0, block_ready = 0;
  logic [31:0] in_data = '0;
  logic [2:0] in_nbytes = '0;
  logic in_ready, block_valid, block_first, block_final;
  logic [511:0] block;
  int n_chk = 0, n_pass = 0;
  sha256_padder #(.LEN_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
    .block_valid(block_valid), .block_ready(block_ready), .block(block),
    .block_first(block_first), .block_final(block_final)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  // padded message = msg, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
  function automatic blocks_t model(input bytes_t msg);
    bytes_t p = msg;
    blocks_t q;
    logic [63:0] bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int k = 0; k < p.size() / 64; k++) begin
      logic [511:0] b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      q.push_back(b);
    end
    return q;
  endfunction
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int t = 0;
    logic acc;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1; in_data = d; in_last = l; in_nbytes = nb;
    do begin
      acc = in_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 3000);
    if (!acc) chk("in_timeout", 0, 1);
    in_valid = 0; in_last = 0;
  endtask
  task automatic drive(input bytes_t msg);
    int len = msg.size();
    int nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d = $urandom;
      logic l = (w == nw - 1);
      logic [2:0] nb = 3'($urandom);
      for (int b = 0; b < 4; b++) if (4*w + b < len) d[31-8*b -: 8] = msg[4*w+b];
      if (l) nb = (len - 4*w == 4 && $urandom_range(0, 1)) ? 3'($urandom_range(4, 7)) : 3'(len - 4*w);
      send_word(d, l, nb);
    end
  endtask
  task automatic collect(input blocks_t exp, input bit stall);
    for (int k = 0; k < exp.size(); k++) begin
      int t = 0;
      while (!block_valid && t < 3000) begin @(negedge clk); t++; end
      if (!block_valid) begin chk("blk_timeout", 0, 1); return; end
      chk($sformatf("blk%0d", k), block, exp[k]);
      chk($sformatf("first%0d", k), block_first, k == 0);
      chk($sformatf("final%0d", k), block_final, k == exp.size() - 1);
      chk($sformatf("rdy_emit%0d", k), in_ready, 0);
      if (stall) repeat (5) begin
        @(negedge clk);
        chk("hold_blk", block, exp[k]);
        chk("hold_valid", block_valid, 1);
        chk("hold_rdy", in_ready, 0);
      end
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      block_ready = 1;
      @(negedge clk);
      block_ready = 0;
      chk("valid_drop", block_valid, 0);
    end
  endtask
  task automatic run_msg(input bytes_t msg, input bit stall);
    blocks_t exp = model(msg);
    fork
      drive(msg);
      collect(exp, stall);
    join
  endtask
  function automatic bytes_t rnd_msg(input int len);
    bytes_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction
  initial begin
    bytes_t abc = '{8'h61, 8'h62, 8'h63};
    logic seen = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", block_valid, 0);
    chk("rst_first", block_first, 1);
    chk("rst_final", block_final, 0);
    chk("rst_inrdy", in_ready, 0);
    chk("rst_block", block, '0);
    reset_n = 1;
    @(negedge clk);
    chk("inrdy_idle", in_ready, 1);
    run_msg(abc, 0);
    run_msg(rnd_msg(0), 0);
    run_msg(rnd_msg(55), 0);
    run_msg(rnd_msg(56), 0);
    run_msg(rnd_msg(64), 1);
    for (int i = 0; i < 7; i++) send_word($urandom, 0, 3'd4);
    reset_n = 0;
    @(negedge clk);
    chk("midrst_inrdy", in_ready, 0);
    reset_n = 1;
    repeat (25) begin @(negedge clk); seen |= block_valid; end
    chk("midrst_noblk", seen, 0);
    run_msg(abc, 0);
    for (int i = 0; i < 14; i++) run_msg(rnd_msg($urandom_range(0, 200)), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
